prim_blank_slice: RTL and testbench

Single-entry valid/ready register slice whose output data is forced to zero unless a multi-bit enable is held stably true. It sits directly upstream of the hardened AND2 gating primitive. It produces both the registered data word and the qualified enable that the AND2 consumes, and it owns the arming sequence and the fault detection for that enable. Typical use is blanking secret or debug data paths under lifecycle control.

---
 rtl/prim_blank_slice_pkg.sv | 19 +
 rtl/prim_mubi_pkg.sv | 10 +
 rtl/prim_and2.sv | 21 ++
 rtl/prim_blank_slice_fsm.sv | 78 +++++++
 rtl/prim_blank_slice.sv | 96 +++++++++
 tb/tb_prim_blank_slice.sv | 198 +++++++++++++++++++
 6 files changed

// File: rtl/prim_blank_slice_pkg.sv
// Types and helpers for prim_blank_slice.
// - state_e: arming FSM states, pairwise Hamming distance >= 2 so that a
//   single flipped state bit never lands on another legal state.
// - cnt_width(): width of the arming counter for a given ArmCycles.
package prim_blank_slice_pkg;

  typedef enum logic [3:0] {
    Blanked = 4'b0011,
    Arming  = 4'b0101,
    Open    = 4'b1001,
    Error   = 4'b1110
  } state_e;

  // The counter must be able to hold ArmCycles-1.
  function automatic int cnt_width(input int arm_cycles);
    return $clog2(arm_cycles + 1);
  endfunction

endpackage

// File: rtl/prim_mubi_pkg.sv
// Multi-bit boolean encodings shared across the primitive library.
// Only the 4-bit flavour is needed by the blanking slice.
package prim_mubi_pkg;

  typedef enum logic [3:0] {
    MuBi4True  = 4'h6,
    MuBi4False = 4'h9
  } mubi4_t;

endpackage

// File: rtl/prim_and2.sv
// Hardened AND2 gating primitive: out_o = in0_i & in1_i, bitwise.
// Ports:
//   in0_i  [Width]  first operand (data)
//   in1_i  [Width]  second operand (gate)
//   out_o  [Width]  gated result
module prim_and2 #(
  parameter int Width = 1
) (
  input  logic [Width-1:0] in0_i,
  input  logic [Width-1:0] in1_i,
  output logic [Width-1:0] out_o
);

  genvar gi;
  generate
    for (gi = 0; gi < Width; gi++) begin : g_bit
      assign out_o[gi] = in0_i[gi] & in1_i[gi];
    end
  endgenerate

endmodule

// File: rtl/prim_blank_slice_fsm.sv
// Arming / fault FSM for prim_blank_slice.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   en_q           registered multi-bit enable
//   state_o        current FSM state
//   open_o         data may be released (Open and enable still True)
//   err_o          sticky: an invalid enable encoding was observed
module prim_blank_slice_fsm
  import prim_mubi_pkg::*;
  import prim_blank_slice_pkg::*;
#(
  parameter int ArmCycles = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  mubi4_t en_q,
  output state_e state_o,
  output logic   open_o,
  output logic   err_o
);

  localparam int CntW = cnt_width(ArmCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(ArmCycles - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q;
  logic            en_true, en_false, en_valid;

  assign en_true  = (en_q == MuBi4True);
  assign en_false = (en_q == MuBi4False);
  assign en_valid = en_true | en_false;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;  // counter only holds a non-zero value while Arming
    case (state_q)
      Blanked: if (en_true) state_d = Arming;
      Arming: begin
        if (en_false) begin
          state_d = Blanked;
        end else if (cnt_q == CntLast) begin
          state_d = Open;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      Open:    if (en_false) state_d = Blanked;
      Error:   state_d = Error;
      default: state_d = Error;  // corrupted state register
    endcase
    // An invalid encoding overrides every other transition.
    if (!en_valid) begin
      state_d = Error;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Blanked;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_q | (state_d == Error);
    end
  end

  assign state_o = state_q;
  // The en_q term lets a False/invalid enable blank one cycle before the
  // FSM itself leaves Open.
  assign open_o  = (state_q == Open) && en_true;
  assign err_o   = err_q;

endmodule

// File: rtl/prim_blank_slice.sv
// Single-entry valid/ready register slice whose output is forced to zero
// unless a multi-bit enable has been held True for ArmCycles cycles.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   en_i                multi-bit enable (MuBi4)
//   valid_i/ready_o/data_i   upstream handshake
//   valid_o/ready_i/data_o   downstream handshake, data_o zero when blanked
//   blanked_o           high whenever data is not released
//   err_o               sticky invalid-enable fault
module prim_blank_slice
  import prim_mubi_pkg::*;
  import prim_blank_slice_pkg::*;
#(
  parameter int Width     = 32,
  parameter int ArmCycles = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  mubi4_t           en_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic             blanked_o,
  output logic             err_o
);

  mubi4_t           en_q;
  state_e           state;
  logic             open;
  logic             in_error;
  logic             valid_q;
  logic [Width-1:0] data_q;
  logic             accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= MuBi4False;
    end else begin
      en_q <= en_i;
    end
  end

  prim_blank_slice_fsm #(
    .ArmCycles (ArmCycles)
  ) u_fsm (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_q    (en_q),
    .state_o (state),
    .open_o  (open),
    .err_o   (err_o)
  );

  assign in_error = (state == Error);

  // While blanked the entry is held rather than drained; only an empty slot
  // may accept. Once open, a departing entry frees the slot the same cycle.
  always_comb begin
    ready_o = 1'b0;
    if (!in_error) begin
      ready_o = open ? (!valid_q || ready_i) : !valid_q;
    end
  end

  assign accept  = valid_i && ready_o;
  assign valid_o = open && valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_error) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (valid_o && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  prim_and2 #(
    .Width (Width)
  ) u_and2 (
    .in0_i (data_q),
    .in1_i ({Width{open}}),
    .out_o (data_o)
  );

  assign blanked_o = !open;

endmodule

// File: tb/tb_prim_blank_slice.sv
module tb_prim_blank_slice;
  import prim_mubi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  mubi4_t      en;
  logic        vi, ri;
  logic [31:0] di;
  logic        valid_o, ready_o, blanked_o, err_o;
  logic [31:0] data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prim_blank_slice #(
    .Width     (32),
    .ArmCycles (4)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (en),
    .valid_i   (vi),
    .ready_o   (ready_o),
    .data_i    (di),
    .valid_o   (valid_o),
    .ready_i   (ri),
    .data_o    (data_o),
    .blanked_o (blanked_o),
    .err_o     (err_o)
  );

  typedef struct {
    logic [3:0]  en;
    logic        vi;
    logic        ri;
    logic [31:0] di;
    logic        ev;
    logic        er;
    logic [31:0] ed;
    logic        eb;
    logic        ee;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic ev, input logic er,
                     input logic [31:0] ed, input logic eb, input logic ee);
    checks++;
    if (valid_o !== ev || ready_o !== er || data_o !== ed ||
        blanked_o !== eb || err_o !== ee) begin
      errors++;
      $display("FAIL %s: got v=%b r=%b d=%h b=%b e=%b, want v=%b r=%b d=%h b=%b e=%b",
               name, valid_o, ready_o, data_o, blanked_o, err_o, ev, er, ed, eb, ee);
    end else begin
      $display("ok   %s: v=%b r=%b d=%h b=%b e=%b", name, valid_o, ready_o, data_o,
               blanked_o, err_o);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = MuBi4False;
    vi    = 1'b0;
    ri    = 1'b0;
    di    = '0;

    // Arming: enable True from edge 0, one beat pushed at edge 0.
    vecs[0] = '{4'h6, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[1] = '{4'h6, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[2] = '{4'h6, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[3] = '{4'h6, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[4] = '{4'h6, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[5] = '{4'h6, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[6] = '{4'h6, 1'b0, 1'b1, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};

    #2;
    chk("reset", 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      en = mubi4_t'(vecs[i].en);
      vi = vecs[i].vi;
      ri = vecs[i].ri;
      di = vecs[i].di;
      step();
      chk($sformatf("arm[%0d]", i), vecs[i].ev, vecs[i].er, vecs[i].ed,
          vecs[i].eb, vecs[i].ee);
    end

    // Throughput: 16 back-to-back beats, 1-cycle latency.
    for (int i = 0; i < 16; i++) begin
      vi = 1'b1;
      ri = 1'b1;
      di = 32'(i);
      step();
      chk($sformatf("tput[%0d]", i), 1'b1, 1'b1, 32'(i), 1'b0, 1'b0);
    end
    vi = 1'b0;
    step();
    chk("tput_drain", 1'b0, 1'b1, 32'd15, 1'b0, 1'b0);

    // Blank a held entry, then re-arm and expect it re-presented.
    vi = 1'b1; ri = 1'b0; di = 32'hCAFEF00D;
    step();
    chk("blk_hold", 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);
    vi = 1'b0;
    en = MuBi4False;
    step();
    chk("blk_fast", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    chk("blk_fsm", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    en = MuBi4True;
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("rearm[%0d]", n), 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    end
    step();
    chk("represent", 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);
    ri = 1'b1;
    step();
    chk("represent_take", 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    ri = 1'b0;

    // Enable glitch during Arming restarts the count.
    en = MuBi4False;
    step();
    step();
    en = MuBi4True;
    step();
    step();
    step();
    chk("glitch_pre", 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    en = MuBi4False;
    step();
    en = MuBi4True;
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("glitch[%0d]", n), 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    end
    step();
    chk("glitch_open", 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);

    // Invalid encoding while Open with an entry held.
    vi = 1'b1; di = 32'h12345678;
    step();
    chk("inv_hold", 1'b1, 1'b0, 32'h12345678, 1'b0, 1'b0);
    vi = 1'b0;
    en = mubi4_t'(4'h0);
    step();
    chk("inv_fast", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    en = MuBi4True;
    step();
    chk("inv_err", 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    vi = 1'b1; ri = 1'b1; di = 32'hAAAA5555;
    for (int n = 0; n < 8; n++) begin
      step();
      chk($sformatf("err_stuck[%0d]", n), 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    end

    // Reset pulse clears the fault.
    vi = 1'b0; ri = 1'b0; en = MuBi4False;
    rst_n = 1'b0;
    #2;
    chk("err_rst", 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b1;

    // Async reset mid-Arming with an entry held.
    en = MuBi4True; vi = 1'b1; di = 32'h0BADCAFE;
    step();
    chk("ar_push", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    vi = 1'b0;
    step();
    step();
    chk("ar_arming", 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("ar_async", 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("ar_rearm[%0d]", n), 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
    end
    step();
    chk("ar_open_empty", 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
